// File: rtl/operand_feeder.sv
// Operand FIFO feeding the registered adder: buffers (A,B) pairs and issues one pair per cycle.
// Optional macro OPERAND_FEEDER_DROP_CNT_EN adds a saturating Drop_Cnt of pushes refused while full.
module operand_feeder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic             Push,
    input  logic             Hold,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             En,
    output logic             Full,
    output logic             Empty,
`ifdef OPERAND_FEEDER_DROP_CNT_EN
    output logic [7:0]       Drop_Cnt,
`endif
    output logic [PTR_W:0]   Count
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign Full    = (Count == FullCount);
    assign Empty   = (Count == '0);
    assign push_ok = Push && !Full;
    assign pop_ok  = !Empty && !Hold;

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {In_A, In_B};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
            A      <= '0;
            B      <= '0;
            En     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                {A, B} <= mem[rd_ptr];
                En     <= 1'b1;
            end else begin
                En     <= 1'b0;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

`ifdef OPERAND_FEEDER_DROP_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Drop_Cnt <= '0;
        end else if (Push && Full && (Drop_Cnt != 8'hFF)) begin
            Drop_Cnt <= Drop_Cnt + 1'b1;
        end
    end
`endif

endmodule
